// File: rtl/multiplier_csa.sv
// multiplier_csa: unsigned N x N carry-save array multiplier.
// AND-gate partial products feed N-2 full-adder CSA rows (plus a leading
// half-adder row), then a ripple-carry vector-merge adder forms the upper
// half of the product. The product is registered; reset is synchronous and
// active-high.
// Optional build macro: MULT_CSA_INREG_EN adds operand input registers,
// which makes the latency 2 cycles instead of 1.
module multiplier_csa #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product
);

  logic [N-1:0]          op_a;
  logic [N-1:0]          op_b;
  logic [N-1:0][N-1:0]   pp;
  logic [2*N-1:0]        prod_d;

`ifdef MULT_CSA_INREG_EN
  // Capture the operands ahead of the array; reset clears them too.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else begin
      op_a <= multiplicand;
      op_b <= multiplier;
    end
  end
`else
  assign op_a = multiplicand;
  assign op_b = multiplier;
`endif

  // Partial products: row j is the multiplicand gated by multiplier bit j.
  always_comb begin
    pp = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        pp[j][i] = op_a[i] & op_b[j];
      end
    end
  end

  // Carry-save reduction followed by the ripple-carry merge adder.
  // Before adding row j, s_row[k] carries weight j-1+k and c_row[k] carries
  // weight j+k, so s_row[0] is final and drops straight into the product.
  always_comb begin : csa_array
    logic [N-1:0] s_row;
    logic [N-1:0] c_row;
    logic [N-1:0] s_new;
    logic [N-1:0] c_new;
    logic [N:0]   s_ext;
    logic         add_a;
    logic         rc;

    prod_d = '0;
    s_row  = pp[0];
    c_row  = '0;
    s_new  = '0;
    c_new  = '0;
    s_ext  = '0;
    add_a  = 1'b0;
    rc     = 1'b0;

    for (int j = 1; j < N; j++) begin
      prod_d[j-1] = s_row[0];
      s_ext = {1'b0, s_row};
      // Each bit is an independent full adder; no carry moves within a row.
      for (int k = 0; k < N; k++) begin
        s_new[k] = s_ext[k+1] ^ c_row[k] ^ pp[j][k];
        c_new[k] = (s_ext[k+1] & c_row[k]) |
                   (s_ext[k+1] & pp[j][k]) |
                   (c_row[k]   & pp[j][k]);
      end
      s_row = s_new;
      c_row = c_new;
    end

    prod_d[N-1] = s_row[0];
    s_ext = {1'b0, s_row};

    // Both remaining vectors now align at weight N; the carry out of the
    // top bit is always zero because (2^N-1)^2 fits in 2N bits.
    for (int k = 0; k < N; k++) begin
      add_a       = s_ext[k+1];
      prod_d[N+k] = add_a ^ c_row[k] ^ rc;
      rc          = (add_a & c_row[k]) | (add_a & rc) | (c_row[k] & rc);
    end
  end

  // Product register; reset discards whatever the array is presenting.
  always_ff @(posedge clk) begin
    if (rst) begin
      product <= '0;
    end else begin
      product <= prod_d;
    end
  end

endmodule

// File: tb/tb_multiplier_csa.sv
// Testbench for multiplier_csa: N=4 and N=8 instances driven in lockstep,
// checked against a latency delay-line model built on plain multiplication.
module tb_multiplier_csa;

`ifdef MULT_CSA_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int n_total;
  int n_pass;

  logic [7:0]  exp4_q[$];
  logic [15:0] exp8_q[$];

  multiplier_csa #(.N(4)) dut (
    .clk(clk), .rst(rst), .multiplicand(a4), .multiplier(b4), .product(p4)
  );

  multiplier_csa #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .multiplicand(a8), .multiplier(b8), .product(p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check4(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: product=%h expected=%h", tag, obs, expv);
  endtask

  task automatic check8(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: product=%h expected=%h", tag, obs, expv);
  endtask

  // One clock: drive on the falling edge, sample 1ns after the rising edge.
  task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] x, input logic [7:0] y, input logic r);
    logic [7:0]  e4;
    logic [15:0] e8;
    @(negedge clk);
    a4  = a;
    b4  = b;
    a8  = x;
    b8  = y;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      exp4_q.delete();
      exp8_q.delete();
      for (int i = 0; i < LAT - 1; i++) begin
        exp4_q.push_back(8'h00);
        exp8_q.push_back(16'h0000);
      end
      e4 = 8'h00;
      e8 = 16'h0000;
    end else begin
      exp4_q.push_back(8'(int'(a) * int'(b)));
      exp8_q.push_back(16'(int'(x) * int'(y)));
      e4 = exp4_q.pop_front();
      e8 = exp8_q.pop_front();
    end
    check4({tag, "_n4"}, p4, e4);
    check8({tag, "_n8"}, p8, e8);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    a4 = 4'hF; b4 = 4'hF;
    a8 = 8'hFF; b8 = 8'hFF;

    step("reset0", 4'hF, 4'hF, 8'hFF, 8'hFF, 1'b1);
    step("reset1", 4'hF, 4'hF, 8'hFF, 8'hFF, 1'b1);

    step("c_15x15", 4'd15, 4'd15, 8'd255, 8'd255, 1'b0);
    step("c_0x13",  4'd0,  4'd13, 8'd0,   8'd200, 1'b0);
    step("c_1x13",  4'd1,  4'd13, 8'd1,   8'd173, 1'b0);
    step("c_8x8",   4'd8,  4'd8,  8'd128, 8'd128, 1'b0);
    step("c_15x1",  4'd15, 4'd1,  8'd255, 8'd1,   1'b0);
    step("c_13x0",  4'd13, 4'd0,  8'd77,  8'd0,   1'b0);

    step("b2b_3x5",   4'd3,  4'd5,  8'd3,  8'd5,  1'b0);
    step("b2b_7x9",   4'd7,  4'd9,  8'd7,  8'd9,  1'b0);
    step("b2b_12x11", 4'd12, 4'd11, 8'd12, 8'd11, 1'b0);

    for (int i = 0; i < 256; i++) begin
      logic [7:0] pair;
      pair = 8'(i);
      if (i == 100) begin
        step("mid_rst", pair[7:4], pair[3:0], 8'($urandom), 8'($urandom), 1'b1);
      end
      step("sweep", pair[7:4], pair[3:0], 8'($urandom), 8'($urandom), 1'b0);
    end

    for (int i = 0; i < 200; i++) begin
      step("rand", 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    end

    for (int i = 0; i < LAT; i++) begin
      step("flush", 4'd0, 4'd0, 8'd0, 8'd0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
